// File: rtl/i2c_cmdq_tx_fifo_gen2_if.sv
// Push/pop/status bundle between the I2C Tx command FIFO and its Wishbone, alternate-source and sequencer clients.
// The slave modport is the FIFO side; the master modport is everything that drives it.
interface i2c_cmdq_tx_fifo_gen2_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
);
   localparam int BS_W = DATA_W / 8;
   localparam int AW   = $clog2(DEPTH);

   logic              WBs_CYC_i;
   logic              WBs_STB_i;
   logic              WBs_WE_i;
   logic [BS_W-1:0]   WBs_BYTE_STB_i;
   logic [DATA_W-1:0] WBs_DAT_i;
   logic              WBs_ACK_o;
   logic              Alt_Sel_i;
   logic              Alt_Push_i;
   logic [DATA_W-1:0] Alt_DAT_i;
   logic [BS_W-1:0]   Alt_BYTE_STB_i;
   logic              Tx_FIFO_Flush_i;
   logic              Tx_FIFO_Pop_i;
   logic              Err_Clr_i;
   logic [DATA_W-1:0] Tx_FIFO_DAT_o;
   logic [BS_W-1:0]   Tx_FIFO_BYTE_STB_o;
   logic              Tx_FIFO_Empty_o;
   logic              Tx_FIFO_Full_o;
   logic              Tx_FIFO_Almost_Full_o;
   logic [AW:0]       Tx_FIFO_Level_o;
   logic              Tx_FIFO_Ovf_o;
   logic              Tx_FIFO_Udf_o;

   modport slave (
      input  WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
      input  Alt_Sel_i, Alt_Push_i, Alt_DAT_i, Alt_BYTE_STB_i,
      input  Tx_FIFO_Flush_i, Tx_FIFO_Pop_i, Err_Clr_i,
      output WBs_ACK_o, Tx_FIFO_DAT_o, Tx_FIFO_BYTE_STB_o, Tx_FIFO_Empty_o,
      output Tx_FIFO_Full_o, Tx_FIFO_Almost_Full_o, Tx_FIFO_Level_o,
      output Tx_FIFO_Ovf_o, Tx_FIFO_Udf_o
   );

   modport master (
      output WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
      output Alt_Sel_i, Alt_Push_i, Alt_DAT_i, Alt_BYTE_STB_i,
      output Tx_FIFO_Flush_i, Tx_FIFO_Pop_i, Err_Clr_i,
      input  WBs_ACK_o, Tx_FIFO_DAT_o, Tx_FIFO_BYTE_STB_o, Tx_FIFO_Empty_o,
      input  Tx_FIFO_Full_o, Tx_FIFO_Almost_Full_o, Tx_FIFO_Level_o,
      input  Tx_FIFO_Ovf_o, Tx_FIFO_Udf_o
   );
endinterface

// File: rtl/i2c_cmdq_tx_fifo_gen2.sv
// FWFT Tx FIFO for the I2C command queue: pushed word is at the head right after its push edge; WB ACK is held off while full.
// Define I2C_TXFIFO_BYTE_STB_EN to store per-word byte strobes; otherwise the head strobes read all ones when not empty.
module i2c_cmdq_tx_fifo_gen2 #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = 12
) (
   input logic WBs_CLK_i,
   input logic WBs_RSTn_i,
   i2c_cmdq_tx_fifo_gen2_if.slave bus
);
   localparam int BS_W = DATA_W / 8;
   localparam int AW   = $clog2(DEPTH);
   localparam int LW   = AW + 1;
`ifdef I2C_TXFIFO_BYTE_STB_EN
   localparam int MEM_W = DATA_W + BS_W;
`else
   localparam int MEM_W = DATA_W;
`endif

   logic [MEM_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             empty_q, empty_d, full_q, full_d, af_q, af_d;
   logic             ack_q, ack_d, ovf_q, ovf_d, udf_q, udf_d;

   logic             flush, wb_req, wb_push, alt_try, alt_push, push, pop_ok;
   logic [MEM_W-1:0] wr_word, head_word;

   assign flush    = bus.Tx_FIFO_Flush_i;
   assign wb_req   = bus.WBs_CYC_i & bus.WBs_STB_i & bus.WBs_WE_i & ~ack_q & ~bus.Alt_Sel_i;
   assign wb_push  = wb_req & ~full_q & ~flush;
   assign alt_try  = bus.Alt_Sel_i & bus.Alt_Push_i & ~flush;
   assign alt_push = alt_try & ~full_q;
   assign push     = wb_push | alt_push;
   assign pop_ok   = bus.Tx_FIFO_Pop_i & ~empty_q & ~flush;

`ifdef I2C_TXFIFO_BYTE_STB_EN
   assign wr_word = bus.Alt_Sel_i ? {bus.Alt_BYTE_STB_i, bus.Alt_DAT_i}
                                  : {bus.WBs_BYTE_STB_i, bus.WBs_DAT_i};
`else
   assign wr_word = bus.Alt_Sel_i ? bus.Alt_DAT_i : bus.WBs_DAT_i;
   logic unused_strb;
   assign unused_strb = ^{bus.WBs_BYTE_STB_i, bus.Alt_BYTE_STB_i};
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      empty_d  = empty_q;
      full_d   = full_q;
      ack_d    = wb_push;
      // A new error in the same cycle as a clear keeps the flag set.
      ovf_d    = (alt_try & full_q) | (ovf_q & ~bus.Err_Clr_i);
      udf_d    = (bus.Tx_FIFO_Pop_i & empty_q & ~flush) | (udf_q & ~bus.Err_Clr_i);
      if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop_ok})
         2'b10: begin
            level_d = level_q + LW'(1);
            empty_d = 1'b0;
            full_d  = (level_q == LW'(DEPTH - 1));
         end
         2'b01: begin
            level_d = level_q - LW'(1);
            full_d  = 1'b0;
            empty_d = (level_q == LW'(1));
         end
         default: ;
      endcase
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         empty_d  = 1'b1;
         full_d   = 1'b0;
      end
      af_d = (level_d >= LW'(AF_THRESH));
   end

   always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
      if (!WBs_RSTn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         af_q     <= 1'b0;
         ack_q    <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         af_q     <= af_d;
         ack_q    <= ack_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage has no reset; the head is masked by empty_q so stale contents never leak out.
   always_ff @(posedge WBs_CLK_i) begin
      if (push) mem_q[wr_ptr_q] <= wr_word;
   end

   assign head_word = mem_q[rd_ptr_q];

   assign bus.WBs_ACK_o             = ack_q;
   assign bus.Tx_FIFO_DAT_o         = empty_q ? '0 : head_word[DATA_W-1:0];
`ifdef I2C_TXFIFO_BYTE_STB_EN
   assign bus.Tx_FIFO_BYTE_STB_o    = empty_q ? '0 : head_word[DATA_W +: BS_W];
`else
   assign bus.Tx_FIFO_BYTE_STB_o    = empty_q ? '0 : '1;
`endif
   assign bus.Tx_FIFO_Empty_o       = empty_q;
   assign bus.Tx_FIFO_Full_o        = full_q;
   assign bus.Tx_FIFO_Almost_Full_o = af_q;
   assign bus.Tx_FIFO_Level_o       = level_q;
   assign bus.Tx_FIFO_Ovf_o         = ovf_q;
   assign bus.Tx_FIFO_Udf_o         = udf_q;
endmodule

// File: tb/tb_i2c_cmdq_tx_fifo_gen2.sv
// Directed bench for i2c_cmdq_tx_fifo_gen2 with DATA_W=32, DEPTH=16, AF_THRESH=12.
module tb_i2c_cmdq_tx_fifo_gen2;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   lat;

   always #5 clk = ~clk;

   i2c_cmdq_tx_fifo_gen2_if #(.DATA_W(32), .DEPTH(16)) bus ();

   i2c_cmdq_tx_fifo_gen2 #(.DATA_W(32), .DEPTH(16), .AF_THRESH(12)) dut (
      .WBs_CLK_i (clk),
      .WBs_RSTn_i(rst_n),
      .bus       (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns cycles from request to ACK (50 means it never came), then idles one cycle.
   task automatic wb_write(input logic [31:0] d, input logic [3:0] s, output int l);
      bus.WBs_CYC_i = 1'b1; bus.WBs_STB_i = 1'b1; bus.WBs_WE_i = 1'b1;
      bus.WBs_DAT_i = d;    bus.WBs_BYTE_STB_i = s;
      l = 50;
      for (int i = 1; i <= 50; i++) begin
         tick();
         if (bus.WBs_ACK_o === 1'b1) begin
            l = i;
            break;
         end
      end
      bus.WBs_CYC_i = 1'b0; bus.WBs_STB_i = 1'b0; bus.WBs_WE_i = 1'b0;
      tick();
   endtask

   task automatic alt_push(input logic [31:0] d);
      bus.Alt_DAT_i = d; bus.Alt_BYTE_STB_i = 4'hF; bus.Alt_Push_i = 1'b1;
      tick();
      bus.Alt_Push_i = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.WBs_CYC_i = 0; bus.WBs_STB_i = 0; bus.WBs_WE_i = 0;
      bus.WBs_BYTE_STB_i = 0; bus.WBs_DAT_i = 0;
      bus.Alt_Sel_i = 0; bus.Alt_Push_i = 0; bus.Alt_DAT_i = 0; bus.Alt_BYTE_STB_i = 0;
      bus.Tx_FIFO_Flush_i = 0; bus.Tx_FIFO_Pop_i = 0; bus.Err_Clr_i = 0;
      #23;
      chk("rst_ack",   bus.WBs_ACK_o, 0);
      chk("rst_empty", bus.Tx_FIFO_Empty_o, 1);
      chk("rst_full",  bus.Tx_FIFO_Full_o, 0);
      chk("rst_af",    bus.Tx_FIFO_Almost_Full_o, 0);
      chk("rst_level", bus.Tx_FIFO_Level_o, 0);
      chk("rst_flags", {bus.Tx_FIFO_Ovf_o, bus.Tx_FIFO_Udf_o}, 0);
      chk("rst_dat",   bus.Tx_FIFO_DAT_o, 0);
      chk("rst_bs",    bus.Tx_FIFO_BYTE_STB_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // First WB write: ACK one cycle after the request, word at head.
      wb_write(32'hA5A5_0001, 4'hF, lat);
      chk("t1_ack_lat", lat, 1);
      chk("t1_ack_drop", bus.WBs_ACK_o, 0);
      chk("t1_empty", bus.Tx_FIFO_Empty_o, 0);
      chk("t1_level", bus.Tx_FIFO_Level_o, 1);
      chk("t1_dat", bus.Tx_FIFO_DAT_o, 32'hA5A5_0001);

      // Fill to DEPTH; almost-full from level 12.
      for (int k = 0; k < 15; k++) begin
         wb_write(32'h1000_0000 + k, 4'hF, lat);
         chk("t2_ack_lat", lat, 1);
         chk("t2_af", bus.Tx_FIFO_Almost_Full_o, (k + 2 >= 12) ? 1 : 0);
      end
      chk("t2_full", bus.Tx_FIFO_Full_o, 1);
      chk("t2_level", bus.Tx_FIFO_Level_o, 16);

      // 17th write stalls until a pop frees a slot.
      bus.WBs_CYC_i = 1; bus.WBs_STB_i = 1; bus.WBs_WE_i = 1;
      bus.WBs_DAT_i = 32'hDEAD_BEEF; bus.WBs_BYTE_STB_i = 4'hF;
      tick(); tick(); tick();
      chk("t2_stall_ack", bus.WBs_ACK_o, 0);
      bus.Tx_FIFO_Pop_i = 1;
      tick();
      bus.Tx_FIFO_Pop_i = 0;
      chk("t2_pop_level", bus.Tx_FIFO_Level_o, 15);
      chk("t2_pop_ack", bus.WBs_ACK_o, 0);
      tick();
      chk("t2_late_ack", bus.WBs_ACK_o, 1);
      chk("t2_refill_level", bus.Tx_FIFO_Level_o, 16);
      bus.WBs_CYC_i = 0; bus.WBs_STB_i = 0; bus.WBs_WE_i = 0;
      chk("t2_head", bus.Tx_FIFO_DAT_o, 32'h1000_0000);
      tick();

      // Alternate push while full is dropped and flagged.
      bus.Alt_Sel_i = 1;
      alt_push(32'h5555_5555);
      chk("t3_ovf", bus.Tx_FIFO_Ovf_o, 1);
      chk("t3_level", bus.Tx_FIFO_Level_o, 16);
      chk("t3_head", bus.Tx_FIFO_DAT_o, 32'h1000_0000);
      bus.Err_Clr_i = 1;
      tick();
      bus.Err_Clr_i = 0;
      chk("t3_ovf_clr", bus.Tx_FIFO_Ovf_o, 0);

      // Underflow, then push+pop across the pointer wrap.
      bus.Tx_FIFO_Flush_i = 1;
      tick();
      bus.Tx_FIFO_Flush_i = 0;
      chk("t4_flush_level", bus.Tx_FIFO_Level_o, 0);
      chk("t4_flush_empty", bus.Tx_FIFO_Empty_o, 1);
      bus.Tx_FIFO_Pop_i = 1;
      tick();
      bus.Tx_FIFO_Pop_i = 0;
      chk("t4_udf", bus.Tx_FIFO_Udf_o, 1);
      chk("t4_udf_level", bus.Tx_FIFO_Level_o, 0);
      bus.Err_Clr_i = 1;
      tick();
      bus.Err_Clr_i = 0;
      chk("t4_udf_clr", bus.Tx_FIFO_Udf_o, 0);
      for (int k = 0; k < 5; k++) alt_push(32'hC000_0000 + k);
      chk("t4_level5", bus.Tx_FIFO_Level_o, 5);
      for (int k = 5; k < 19; k++) begin
         bus.Tx_FIFO_Pop_i = 1;
         alt_push(32'hC000_0000 + k);
      end
      bus.Tx_FIFO_Pop_i = 0;
      chk("t4_pp_level", bus.Tx_FIFO_Level_o, 5);
      for (int k = 14; k < 19; k++) begin
         chk("t4_order", bus.Tx_FIFO_DAT_o, 32'hC000_0000 + k);
         bus.Tx_FIFO_Pop_i = 1;
         tick();
         bus.Tx_FIFO_Pop_i = 0;
      end
      chk("t4_drained", bus.Tx_FIFO_Empty_o, 1);
      bus.Tx_FIFO_Pop_i = 1;
      tick();
      bus.Tx_FIFO_Pop_i = 0;
      chk("t4_udf_again", bus.Tx_FIFO_Udf_o, 1);

      // Flush beats a same-cycle push and pop; sticky flags survive.
      for (int k = 0; k < 9; k++) alt_push(32'hD000_0000 + k);
      chk("t5_level9", bus.Tx_FIFO_Level_o, 9);
      bus.Tx_FIFO_Flush_i = 1; bus.Tx_FIFO_Pop_i = 1;
      alt_push(32'hEEEE_EEEE);
      bus.Tx_FIFO_Flush_i = 0; bus.Tx_FIFO_Pop_i = 0;
      chk("t5_level", bus.Tx_FIFO_Level_o, 0);
      chk("t5_empty", bus.Tx_FIFO_Empty_o, 1);
      chk("t5_dat", bus.Tx_FIFO_DAT_o, 0);
      chk("t5_flags", {bus.Tx_FIFO_Ovf_o, bus.Tx_FIFO_Udf_o}, 2'b01);
      bus.Alt_Sel_i = 0;

      // Byte strobes at the head.
      wb_write(32'h1234_5678, 4'b0011, lat);
      chk("t6_ack_lat", lat, 1);
      chk("t6_dat", bus.Tx_FIFO_DAT_o, 32'h1234_5678);
`ifdef I2C_TXFIFO_BYTE_STB_EN
      chk("t6_bs", bus.Tx_FIFO_BYTE_STB_o, 4'b0011);
`else
      chk("t6_bs", bus.Tx_FIFO_BYTE_STB_o, 4'hF);
`endif

      // Asynchronous reset mid-operation.
      #2;
      rst_n = 1'b0;
      #1;
      chk("t7_level", bus.Tx_FIFO_Level_o, 0);
      chk("t7_empty", bus.Tx_FIFO_Empty_o, 1);
      chk("t7_flags", {bus.Tx_FIFO_Ovf_o, bus.Tx_FIFO_Udf_o}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
